// File: rtl/decode_in_feeder.sv
// rtl/decode_in_feeder.sv - issue buffer feeding {instr,npc,sr} entries to decode
//
// Purpose: DEPTH-entry FIFO between fetch and decode. Each entry is presented
//          to decode with a one-cycle en_decode qualifier.
// Ports:
//   clock        in   sole clock, rising edge
//   reset        in   synchronous, active-high
//   push_valid   in   upstream offers an entry
//   push_ready   out  entry accepted this cycle when push_valid is high
//   push_instr   in   [15:0] instruction word
//   push_npc     in   [15:0] next-PC paired with the instruction
//   push_sr      in   [2:0]  NZP status paired with the instruction
//   stall        in   decode cannot take an issue this cycle
//   flush        in   discard all buffered entries
//   instr_dout   out  [15:0] instruction presented to decode
//   npc_in       out  [15:0] next-PC presented to decode
//   Sr           out  [2:0]  status presented to decode
//   en_decode    out  one-cycle qualifier for a new issue
//   issued_count out  [15:0] issues since reset, wraps
module decode_in_feeder #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [15:0] push_instr,
  input  logic [15:0] push_npc,
  input  logic [2:0]  push_sr,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] instr_dout,
  output logic [15:0] npc_in,
  output logic [2:0]  Sr,
  output logic        en_decode,
  output logic [15:0] issued_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_READY   = 2'd1,
    ST_STALLED = 2'd2
  } state_t;

  logic [34:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  logic          push;
  logic          pop;

  // State is a pure decode of occupancy and the current stall request.
  always_comb begin
    state = ST_EMPTY;
    if (count != '0) begin
      state = stall ? ST_STALLED : ST_READY;
    end
  end

  // Handshakes. push_ready looks only at count, so a full FIFO refuses a push
  // even when a pop drains an entry in the same cycle.
  always_comb begin
    push_ready = (count < FULL) && !reset && !flush;
    push       = push_valid && push_ready;
    pop        = (state == ST_READY) && !flush;
  end

  // Entry storage; push is already gated by reset and flush.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {push_instr, push_npc, push_sr};
    end
  end

  // Pointers, occupancy and the issue register. Pointers wrap on their own
  // because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      instr_dout   <= '0;
      npc_in       <= '0;
      Sr           <= '0;
      en_decode    <= 1'b0;
      issued_count <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      en_decode <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        {instr_dout, npc_in, Sr} <= mem[rd_ptr];
        rd_ptr       <= rd_ptr + AW'(1);
        issued_count <= issued_count + 16'd1;
      end
      en_decode <= pop;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_in_feeder.sv
// tb/tb_decode_in_feeder.sv - randomized and directed bench for decode_in_feeder
module tb_decode_in_feeder;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        push_valid;
  logic        push_ready;
  logic [15:0] push_instr;
  logic [15:0] push_npc;
  logic [2:0]  push_sr;
  logic        stall;
  logic        flush;
  logic [15:0] instr_dout;
  logic [15:0] npc_in;
  logic [2:0]  Sr;
  logic        en_decode;
  logic [15:0] issued_count;

  decode_in_feeder #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .push_valid   (push_valid),
    .push_ready   (push_ready),
    .push_instr   (push_instr),
    .push_npc     (push_npc),
    .push_sr      (push_sr),
    .stall        (stall),
    .flush        (flush),
    .instr_dout   (instr_dout),
    .npc_in       (npc_in),
    .Sr           (Sr),
    .en_decode    (en_decode),
    .issued_count (issued_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of pending entries plus the last issued entry.
  logic [34:0] q[$];
  logic [15:0] m_instr, m_npc, m_issued;
  logic [2:0]  m_sr;
  logic        m_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] npc,
                       input logic [2:0] sr, input logic st, input logic fl);
    push_valid = v;
    push_instr = ins;
    push_npc   = npc;
    push_sr    = sr;
    stall      = st;
    flush      = fl;
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic step(input string tag);
    logic        exp_ready;
    logic        do_pop;
    logic [34:0] head;
    #1;
    exp_ready = !reset && !flush && (q.size() < DEPTH);
    check({tag, "_ready"}, {31'd0, push_ready}, {31'd0, exp_ready});
    @(posedge clock);
    if (reset) begin
      q.delete();
      m_instr = '0; m_npc = '0; m_sr = '0; m_en = 1'b0; m_issued = '0;
    end else if (flush) begin
      q.delete();
      m_en = 1'b0;
    end else begin
      do_pop = (q.size() > 0) && !stall;
      m_en = do_pop;
      if (do_pop) begin
        head = q.pop_front();
        {m_instr, m_npc, m_sr} = head;
        m_issued = m_issued + 16'd1;
      end
      if (push_valid && exp_ready) q.push_back({push_instr, push_npc, push_sr});
    end
    #1;
    check({tag, "_en"},     {31'd0, en_decode}, {31'd0, m_en});
    check({tag, "_instr"},  {16'd0, instr_dout}, {16'd0, m_instr});
    check({tag, "_npc"},    {16'd0, npc_in},     {16'd0, m_npc});
    check({tag, "_sr"},     {29'd0, Sr},         {29'd0, m_sr});
    check({tag, "_issued"}, {16'd0, issued_count}, {16'd0, m_issued});
  endtask

  initial begin
    int guard;
    logic [15:0] tag_word;

    reset = 1'b1;
    drive(1'b1, 16'hFFFF, 16'hFFFF, 3'b111, 1'b0, 1'b0);
    step("reset");
    step("reset");
    check("reset_en", {31'd0, en_decode}, 32'd0);
    check("reset_issued", {16'd0, issued_count}, 32'd0);
    reset = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 3'b0, 1'b0, 1'b0);
    step("post_reset");

    // Single issue
    drive(1'b1, 16'h1234, 16'h3001, 3'b010, 1'b0, 1'b0);
    step("single_push");
    drive(1'b0, 16'h0, 16'h0, 3'b0, 1'b0, 1'b0);
    step("single_issue");
    check("single_en", {31'd0, en_decode}, 32'd1);
    check("single_instr", {16'd0, instr_dout}, 32'h1234);
    check("single_npc", {16'd0, npc_in}, 32'h3001);
    check("single_sr", {29'd0, Sr}, 32'd2);
    step("single_hold");
    check("single_hold_en", {31'd0, en_decode}, 32'd0);
    check("single_hold_instr", {16'd0, instr_dout}, 32'h1234);
    check("single_count", {16'd0, issued_count}, 32'd1);

    // Fill under stall, refuse a fifth, then drain back to back
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'hA000 + 16'(i), 16'h4000 + 16'(i), 3'(i), 1'b1, 1'b0);
      step("fill_push");
    end
    drive(1'b1, 16'hA004, 16'h4004, 3'd4, 1'b1, 1'b0);
    #1;
    check("full_not_ready", {31'd0, push_ready}, 32'd0);
    step("full_push");
    drive(1'b0, 16'h0, 16'h0, 3'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("drain");
      check("drain_en", {31'd0, en_decode}, 32'd1);
      check("drain_order", {16'd0, instr_dout}, {16'd0, 16'hA000 + 16'(i)});
    end
    step("drain_empty");
    check("drain_empty_en", {31'd0, en_decode}, 32'd0);

    // Stall mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'hB000 + 16'(i), 16'h5000, 3'b001, 1'b1, 1'b0);
      step("stall_fill");
    end
    drive(1'b0, 16'h0, 16'h0, 3'b0, 1'b0, 1'b0);
    step("stall_first");
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step("stall_hold");
      check("stall_hold_en", {31'd0, en_decode}, 32'd0);
      check("stall_hold_instr", {16'd0, instr_dout}, 32'hB000);
    end
    stall = 1'b0;
    for (int i = 1; i < 3; i++) begin
      step("stall_resume");
      check("stall_resume_instr", {16'd0, instr_dout}, {16'd0, 16'hB000 + 16'(i)});
    end

    // Flush with simultaneous push
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'hC000 + 16'(i), 16'h6000, 3'b100, 1'b1, 1'b0);
      step("flush_fill");
    end
    drive(1'b1, 16'hC003, 16'h6003, 3'b100, 1'b0, 1'b1);
    step("flush");
    drive(1'b0, 16'h0, 16'h0, 3'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("after_flush");
      check("after_flush_en", {31'd0, en_decode}, 32'd0);
    end

    // Interleaved push/pop through the small FIFO
    tag_word = 16'hD000;
    for (int i = 0; i < 60; i++) begin
      drive($urandom_range(0, 1) == 1, tag_word, 16'($urandom), 3'($urandom),
            $urandom_range(0, 2) == 0, 1'b0);
      if (push_valid && (q.size() < DEPTH)) tag_word = tag_word + 16'd1;
      step("interleave");
    end

    // Reset mid-stream while an issue is on the outputs
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'hE000 + 16'(i), 16'h7000, 3'b011, 1'b1, 1'b0);
      step("rst_fill");
    end
    drive(1'b0, 16'h0, 16'h0, 3'b0, 1'b0, 1'b0);
    step("rst_issue");
    check("rst_issue_en", {31'd0, en_decode}, 32'd1);
    reset = 1'b1;
    step("rst_mid");
    reset = 1'b0;
    check("rst_mid_instr", {16'd0, instr_dout}, 32'd0);
    check("rst_mid_issued", {16'd0, issued_count}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step("rst_quiet");
      check("rst_quiet_en", {31'd0, en_decode}, 32'd0);
    end

    // Fully random traffic including occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 1) == 1, 16'($urandom), 16'($urandom), 3'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
      step("random");
    end
    reset = 1'b0;

    // Run issued_count up to its wrap with one issue per cycle
    drive(1'b1, 16'h0F0F, 16'hF0F0, 3'b101, 1'b0, 1'b0);
    guard = 0;
    while (m_issued != 16'hFFFF && guard < 70000) begin
      push_instr = 16'(guard);
      step("wrap_run");
      guard++;
    end
    check("wrap_reached", {31'd0, m_issued == 16'hFFFF}, 32'd1);
    check("wrap_pre", {16'd0, issued_count}, 32'hFFFF);
    step("wrap_edge");
    check("wrap_zero", {16'd0, issued_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
